float_arbiter: RTL and testbench

Shares the single multicycle float unit (s2 port: dataa/datab/n/start/done/result) between N_REQ requesters, e.g. per-microphone gain_dma channels. Round-robin grant. Registers the winner's operands, pulses start, waits for done, then returns the result to the winner with a one-cycle ack. A watchdog aborts hung operations, reports an error and pulses a reset to the float unit.

---
 rtl/float_arb_pkg.sv | 34 +++
 rtl/float_arbiter_rr_arbiter.sv | 55 +++++
 rtl/float_arbiter.sv | 164 ++++++++++++++++
 tb/tb_float_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_arb_pkg.sv
// -----------------------------------------------------------------------------
// float_arb_pkg
// Shared definitions for the float-unit arbiter and its clients (gain_dma):
//   - arb_state_e : arbiter FSM states
//   - FP_OP_*     : operation select codes driven on the float unit's n port
//   - clog2()     : elaboration-time ceiling log2, used to size counters/indices
// -----------------------------------------------------------------------------
package float_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Operation select codes understood by the float unit.
    localparam logic [2:0] FP_OP_ADD  = 3'd0;
    localparam logic [2:0] FP_OP_SUB  = 3'd1;
    localparam logic [2:0] FP_OP_MUL  = 3'd2;
    localparam logic [2:0] FP_OP_DIV  = 3'd3;
    localparam logic [2:0] FP_OP_ITOF = 3'd4;
    localparam logic [2:0] FP_OP_FTOI = 3'd5;
    localparam logic [2:0] FP_OP_SQRT = 3'd6;

    // Ceiling log2; clog2(TIMEOUT+1) gives the watchdog width.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/float_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick plus the registered search pointer.
//   clk, rst   : clock, asynchronous active-high reset (pointer -> 0)
//   req_i      : request vector
//   update_i   : strobe; pointer moves to one past last_i
//   last_i     : index of the requester just served
//   grant_o    : first set request at or above the pointer (with wrap)
//   valid_o    : any request set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             update_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!valid_o && req_i[idx]) begin
                grant_o = IDX_W'(idx);
                valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = (last_i == IDX_W'(N_REQ - 1)) ? '0 : last_i + IDX_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/float_arbiter.sv
// -----------------------------------------------------------------------------
// float_arbiter
// Shares one multicycle float unit between N_REQ requesters. Round-robin
// grant, registers the winner's operands, pulses s2_start, waits for s2_done
// (bounded by a TIMEOUT-cycle watchdog) and returns the result with a
// one-cycle one-hot ack.
//   CLK, RESET                      : clock, asynchronous active-high reset
//   req / req_dataa/_datab/_n       : per-requester request level and operands
//   ack, resp_result, resp_err      : completion pulse, result, timeout flag
//   busy                            : arbiter not idle
//   s2_dataa/_datab/_n/_start/_reset: float unit command side
//   s2_done, s2_result              : float unit completion side
// -----------------------------------------------------------------------------
module float_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_dataa,
    input  logic [N_REQ*W-1:0] req_datab,
    input  logic [N_REQ*3-1:0] req_n,
    output logic [N_REQ-1:0]   ack,
    output logic [W-1:0]       resp_result,
    output logic               resp_err,
    output logic               busy,
    output logic [W-1:0]       s2_dataa,
    output logic [W-1:0]       s2_datab,
    output logic [2:0]         s2_n,
    output logic               s2_start,
    output logic               s2_reset,
    input  logic               s2_done,
    input  logic [W-1:0]       s2_result
);

    import float_arb_pkg::*;

    localparam int IDX_W = clog2(N_REQ);
    localparam int WD_W  = clog2(TIMEOUT + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [W-1:0]     dataa_q, dataa_d, datab_q, datab_d;
    logic [2:0]       n_q, n_d;
    logic [W-1:0]     result_q, result_d;
    logic             err_q, err_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             s2_reset_q, s2_reset_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             ptr_update;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk      (CLK),
        .rst      (RESET),
        .req_i    (req),
        .update_i (ptr_update),
        .last_i   (g_q),
        .grant_o  (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        dataa_d    = dataa_q;
        datab_d    = datab_q;
        n_d        = n_q;
        result_d   = result_q;
        err_d      = err_q;
        wd_d       = wd_q;
        s2_reset_d = 1'b0;
        ptr_update = 1'b0;
        case (state_q)
            IDLE: begin
                // req is only looked at here; changes in other states are ignored.
                if (pick_valid) begin
                    g_d     = pick_idx;
                    dataa_d = req_dataa[int'(pick_idx)*W +: W];
                    datab_d = req_datab[int'(pick_idx)*W +: W];
                    n_d     = req_n[int'(pick_idx)*3 +: 3];
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (s2_done) begin
                    result_d = s2_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else begin
                    wd_d    = WD_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A done arriving on the final watchdog cycle still wins.
                if (s2_done) begin
                    result_d = s2_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (wd_q == WD_W'(TIMEOUT)) begin
                    result_d   = '0;
                    err_d      = 1'b1;
                    s2_reset_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            RESP: begin
                ptr_update = 1'b1;
                wd_d       = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            g_q        <= '0;
            dataa_q    <= '0;
            datab_q    <= '0;
            n_q        <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            wd_q       <= '0;
            s2_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            dataa_q    <= dataa_d;
            datab_q    <= datab_d;
            n_q        <= n_d;
            result_q   <= result_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
            s2_reset_q <= s2_reset_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == RESP) ack[g_q] = 1'b1;
    end

    assign resp_result = (state_q == RESP) ? result_q : '0;
    assign resp_err    = (state_q == RESP) ? err_q : 1'b0;
    assign busy        = (state_q != IDLE);
    assign s2_start    = (state_q == ISSUE);
    assign s2_reset    = s2_reset_q;
    assign s2_dataa    = dataa_q;
    assign s2_datab    = datab_q;
    assign s2_n        = n_q;

endmodule

// File: tb/tb_float_arbiter.sv
// -----------------------------------------------------------------------------
// tb_float_arbiter
// Directed stimulus against float_arbiter with a stand-in float unit whose
// latency is programmable (fu_lat < 0 means it never answers). A transaction
// timeline model predicts, from the round-robin and latency rules, when each
// grant starts and acks; a compare process checks the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_float_arbiter;

    import float_arb_pkg::*;

    localparam int N       = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;

    logic             CLK;
    logic             RESET;
    logic [N-1:0]     req_v;
    logic [N*W-1:0]   req_dataa;
    logic [N*W-1:0]   req_datab;
    logic [N*3-1:0]   req_n;
    logic [N-1:0]     ack;
    logic [W-1:0]     resp_result;
    logic             resp_err;
    logic             busy;
    logic [W-1:0]     s2_dataa;
    logic [W-1:0]     s2_datab;
    logic [2:0]       s2_n;
    logic             s2_start;
    logic             s2_reset;
    logic             s2_done;
    logic [W-1:0]     s2_result;

    float_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .req         (req_v),
        .req_dataa   (req_dataa),
        .req_datab   (req_datab),
        .req_n       (req_n),
        .ack         (ack),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy),
        .s2_dataa    (s2_dataa),
        .s2_datab    (s2_datab),
        .s2_n        (s2_n),
        .s2_start    (s2_start),
        .s2_reset    (s2_reset),
        .s2_done     (s2_done),
        .s2_result   (s2_result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Exact-case single-precision multiply (normal operands, truncating).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        logic [22:0] f;
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (m[47]) begin f = m[46:24]; e = e + 10'd1; end
        else       f = m[45:23];
        return {a[31] ^ b[31], e[7:0], f};
    endfunction

    // ---------------- stand-in float unit (multiply only) ----------------
    int   fu_lat = 5;
    int   fu_cnt;
    logic fu_busy;
    logic inject_done = 1'b0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET)                       fu_busy <= 1'b0;
        else if (s2_reset)               fu_busy <= 1'b0;
        else if (s2_start && fu_lat > 0) begin fu_busy <= 1'b1; fu_cnt <= fu_lat - 1; end
        else if (fu_busy) begin
            if (fu_cnt == 0) fu_busy <= 1'b0;
            else             fu_cnt  <= fu_cnt - 1;
        end
    end

    assign s2_done   = inject_done | (fu_lat == 0 && s2_start) | (fu_busy && fu_cnt == 0);
    assign s2_result = s2_done ? fmul(s2_dataa, s2_datab) : 32'hDEAD_BEEF;

    // ---------------- transaction timeline model ----------------
    // A grant sampled at edge e: ISSUE in cycle e, ack in cycle e+1+L
    // (L = TIMEOUT on a hang), next request sampled at edge e+3+L.
    int          cyc = 0;
    bit          op_valid = 1'b0;
    int          m_ptr = 0;
    int          next_sample = 0;
    int          m_pick, m_lat;
    int          ex_g, ex_grant, ex_ack;
    logic [31:0] ex_a, ex_b, ex_res;
    logic [2:0]  ex_n;
    logic        ex_err;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_valid    = 1'b0;
            m_ptr       = 0;
            next_sample = 0;
        end else begin
            cyc = cyc + 1;
            if (cyc >= next_sample && req_v != '0) begin
                m_pick = -1;
                for (int k = 0; k < N; k++)
                    if (m_pick < 0 && req_v[(m_ptr + k) % N]) m_pick = (m_ptr + k) % N;
                ex_err   = (fu_lat < 0 || fu_lat > TIMEOUT);
                m_lat    = ex_err ? TIMEOUT : fu_lat;
                ex_g     = m_pick;
                ex_a     = req_dataa[m_pick*W +: W];
                ex_b     = req_datab[m_pick*W +: W];
                ex_n     = req_n[m_pick*3 +: 3];
                ex_res   = ex_err ? 32'd0 : fmul(ex_a, ex_b);
                ex_grant = cyc;
                ex_ack   = cyc + 1 + m_lat;
                next_sample = cyc + 3 + m_lat;
                m_ptr    = (m_pick + 1) % N;
                op_valid = 1'b1;
            end
        end
    end

    logic [N-1:0] e_ack;
    logic         e_start, e_busy, e_rst;

    always @(negedge CLK) begin
        e_ack = '0;
        if (op_valid && cyc == ex_ack) e_ack[ex_g] = 1'b1;
        e_start = op_valid && cyc == ex_grant;
        e_busy  = op_valid && cyc >= ex_grant && cyc <= ex_ack;
        e_rst   = op_valid && cyc == ex_ack && ex_err;
        check("ack", 64'(ack), 64'(e_ack));
        check("s2_start", 64'(s2_start), 64'(e_start));
        check("busy", 64'(busy), 64'(e_busy));
        check("s2_reset", 64'(s2_reset), 64'(e_rst));
        if (e_busy) begin
            check("s2_dataa", 64'(s2_dataa), 64'(ex_a));
            check("s2_datab", 64'(s2_datab), 64'(ex_b));
            check("s2_n", 64'(s2_n), 64'(ex_n));
        end
        if (e_ack != '0) begin
            check("resp_result", 64'(resp_result), 64'(ex_res));
            check("resp_err", 64'(resp_err), 64'(ex_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [N-1:0] hold_mask = '0;

    task automatic set_op(input int ch, input logic [31:0] a, input logic [31:0] b, input logic [2:0] n);
        req_dataa[ch*W +: W] = a;
        req_datab[ch*W +: W] = b;
        req_n[ch*3 +: 3]     = n;
    endtask

    // Requesters drop req when they see their ack; held channels re-request.
    task automatic step();
        @(negedge CLK);
        req_v = (req_v & ~ack) | hold_mask;
    endtask

    int          w_n, w_st, w_bz, w_rs;
    logic [N-1:0] w_who;
    logic [31:0] w_res;
    logic        w_err;

    task automatic wait_ack(input string tag, input int max_cyc);
        bit seen;
        seen = 1'b0;
        w_n = 0; w_who = '0; w_res = '0; w_err = 1'b0; w_st = 0; w_bz = 0; w_rs = 0;
        for (int i = 1; i <= max_cyc && !seen; i++) begin
            @(negedge CLK);
            w_st += int'(s2_start);
            w_bz += int'(busy);
            w_rs += int'(s2_reset);
            if (ack != '0) begin
                seen  = 1'b1;
                w_n   = i;
                w_who = ack;
                w_res = resp_result;
                w_err = resp_err;
            end
            req_v = (req_v & ~ack) | hold_mask;
        end
        check({tag, "_ack_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        #2 RESET = 1'b1;
        req_v = '0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RESET = 1'b0;
        @(negedge CLK);
    endtask

    int gap, max_gap, ch3_served;

    initial begin
        RESET = 1'b1;
        req_v = '0;
        req_dataa = '0;
        req_datab = '0;
        req_n = '0;
        repeat (3) @(negedge CLK);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(resp_result), 64'd0);
        check("rst_s2_dataa", 64'(s2_dataa), 64'd0);
        #2 RESET = 1'b0;
        @(negedge CLK);

        // 1: single request, latency 5
        fu_lat = 5;
        set_op(0, 32'h3FC0_0000, 32'h4000_0000, FP_OP_MUL);
        req_v = 4'b0001;
        wait_ack("t1", 20);
        check("t1_start_cycle", 64'(w_st), 64'd1);
        check("t1_ack_cycle", 64'(w_n), 64'd7);
        check("t1_who", 64'(w_who), 64'b0001);
        check("t1_result", 64'(w_res), 64'h4040_0000);
        check("t1_err", 64'(w_err), 64'd0);

        // 2: all four from reset, round-robin order and per-channel products
        apply_reset();
        set_op(1, 32'h4000_0000, 32'h4000_0000, FP_OP_MUL);
        set_op(2, 32'h4040_0000, 32'h4080_0000, FP_OP_MUL);
        set_op(3, 32'h3F00_0000, 32'h4100_0000, FP_OP_MUL);
        req_v = 4'b1111;
        wait_ack("t2a", 20);
        check("t2a_who", 64'(w_who), 64'b0001);
        wait_ack("t2b", 20);
        check("t2b_who", 64'(w_who), 64'b0010);
        check("t2b_period", 64'(w_n), 64'd8);
        check("t2b_result", 64'(w_res), 64'h4080_0000);
        wait_ack("t2c", 20);
        check("t2c_who", 64'(w_who), 64'b0100);
        check("t2c_result", 64'(w_res), 64'h4140_0000);
        wait_ack("t2d", 20);
        check("t2d_who", 64'(w_who), 64'b1000);
        check("t2d_result", 64'(w_res), 64'h4080_0000);
        req_v = 4'b0101;
        wait_ack("t2e", 20);
        check("t2e_wrap_who", 64'(w_who), 64'b0001);
        wait_ack("t2f", 20);
        check("t2f_who", 64'(w_who), 64'b0100);

        // 3: zero-latency done in ISSUE
        fu_lat = 0;
        step();
        req_v = 4'b0010;
        wait_ack("t3", 10);
        check("t3_ack_cycle", 64'(w_n), 64'd2);
        check("t3_busy_cycles", 64'(w_bz), 64'd2);
        check("t3_who", 64'(w_who), 64'b0010);

        // 4: hung float unit -> timeout, late done ignored, then normal op
        fu_lat = -1;
        step();
        req_v = 4'b1000;
        wait_ack("t4", 100);
        check("t4_ack_cycle", 64'(w_n), 64'd66);
        check("t4_err", 64'(w_err), 64'd1);
        check("t4_result", 64'(w_res), 64'd0);
        check("t4_s2_reset_pulses", 64'(w_rs), 64'd1);
        step(); step(); step();
        inject_done = 1'b1;
        step();
        inject_done = 1'b0;
        step();
        check("t4_late_done_ack", 64'(ack), 64'd0);
        check("t4_late_done_busy", 64'(busy), 64'd0);
        fu_lat = 3;
        req_v = 4'b0001;
        wait_ack("t4n", 20);
        check("t4n_ack_cycle", 64'(w_n), 64'd5);
        check("t4n_result", 64'(w_res), 64'h4040_0000);
        check("t4n_err", 64'(w_err), 64'd0);

        // 5: reset in WAIT, pointer back to 0
        fu_lat = 10;
        step();
        req_v = 4'b0100;
        repeat (4) step();
        check("t5_in_wait", 64'(busy), 64'd1);
        #2 RESET = 1'b1;
        #1;
        check("t5_async_busy", 64'(busy), 64'd0);
        check("t5_async_start", 64'(s2_start), 64'd0);
        check("t5_async_dataa", 64'(s2_dataa), 64'd0);
        check("t5_async_ack", 64'(ack), 64'd0);
        req_v = '0;
        step(); step();
        #2 RESET = 1'b0;
        fu_lat = 2;
        step();
        req_v = 4'b1010;
        wait_ack("t5a", 20);
        check("t5a_who", 64'(w_who), 64'b0010);
        check("t5a_ack_cycle", 64'(w_n), 64'd4);
        wait_ack("t5b", 20);
        check("t5b_who", 64'(w_who), 64'b1000);

        // 6: ch3 held, ch0/ch1 alternate, ch2 blips while busy
        fu_lat = 4;
        hold_mask = 4'b1000;
        req_v = req_v | hold_mask;
        gap = 0; max_gap = 0; ch3_served = 0;
        for (int op = 0; op < 8; op++) begin
            req_v = req_v | ((op % 2 == 0) ? 4'b0001 : 4'b0010);
            step(); step();
            req_v[2] = 1'b1;
            step(); step();
            req_v[2] = 1'b0;
            wait_ack("t6", 20);
            if (w_who == 4'b1000) begin ch3_served++; gap = 0; end
            else begin gap++; if (gap > max_gap) max_gap = gap; end
        end
        check("t6_fair_gap", 64'(max_gap <= N - 1), 64'd1);
        check("t6_ch3_served", 64'(ch3_served >= 2), 64'd1);
        hold_mask = '0;
        for (int d = 0; d < 6 && req_v != '0; d++) wait_ack("drain", 20);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

endmodule
